// File: rtl/gcd_pkg.sv
// ============================================================================
// Module   : gcd_pkg
// Brief    : Shared types and constants for the gcd_engine block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gcd_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SUBT    = 3'd1,
        SWAP    = 3'd2,
        BSHIFT  = 3'd3,
        BREDUCE = 3'd4,
        DONE    = 3'd5
    } gcd_state_t;

    localparam logic GCD_MODE_SUB = 1'b0;
    localparam logic GCD_MODE_BIN = 1'b1;

    // Datapath operation issued by the FSM each cycle.
    typedef enum logic [2:0] {
        DP_HOLD     = 3'd0,
        DP_LOAD     = 3'd1,
        DP_SUB_AB   = 3'd2,
        DP_SUB_BA   = 3'd3,
        DP_SWAP     = 3'd4,
        DP_SHR_BOTH = 3'd5,
        DP_SHR_A    = 3'd6,
        DP_SHR_B    = 3'd7
    } dp_op_t;

    function automatic int gcd_k_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gcd_datapath.sv
// ============================================================================
// Module   : gcd_datapath
// Brief    : A/B operand registers, shared power-of-two count k, comparator,
//            subtractors and shifters. Binary-only parts need GCD_BINARY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gcd_datapath
    import gcd_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             a_eq_b,
    output logic             a_lt_b,
    output logic             a_even,
    output logic             b_even,
    output logic [WIDTH-1:0] gcd_val
);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;

    assign a_eq_b = (a_q == b_q);
    assign a_lt_b = (a_q < b_q);
    assign a_even = ~a_q[0];
    assign b_even = ~b_q[0];

`ifdef GCD_BINARY_EN
    localparam int K_W = gcd_k_width(WIDTH);

    logic [K_W-1:0] k_q, k_d;

    // Common factors of two stripped in BSHIFT are restored here.
    assign gcd_val = a_q << k_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            k_q <= '0;
        end else begin
            k_q <= k_d;
        end
    end
`else
    assign gcd_val = a_q;
`endif

    always_comb begin
        a_d = a_q;
        b_d = b_q;
`ifdef GCD_BINARY_EN
        k_d = k_q;
`endif
        case (op)
            DP_LOAD: begin
                a_d = a_in;
                b_d = b_in;
`ifdef GCD_BINARY_EN
                k_d = '0;
`endif
            end
            DP_SUB_AB: a_d = a_q - b_q;
            DP_SUB_BA: b_d = b_q - a_q;
            DP_SWAP: begin
                a_d = b_q;
                b_d = a_q;
            end
`ifdef GCD_BINARY_EN
            DP_SHR_BOTH: begin
                a_d = a_q >> 1;
                b_d = b_q >> 1;
                k_d = k_q + 1'b1;
            end
            DP_SHR_A: a_d = a_q >> 1;
            DP_SHR_B: b_d = b_q >> 1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/gcd_engine.sv
// ============================================================================
// Module   : gcd_engine
// Brief    : Parametrised GCD unit, subtractive or binary (Stein) algorithm,
//            with busy, zero-operand error flag and saturating cycle counter.
// Config   : define GCD_BINARY_EN to build the binary algorithm (mode=1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gcd_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] cycles
);

    gcd_state_t       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;

    dp_op_t           dp_op;
    logic             a_eq_b;
    logic             a_lt_b;
    logic             a_even;
    logic             b_even;
    logic [WIDTH-1:0] gcd_val;
    logic             in_compute;

    gcd_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk     (clk),
        .reset   (reset),
        .op      (dp_op),
        .a_in    (a_in),
        .b_in    (b_in),
        .a_eq_b  (a_eq_b),
        .a_lt_b  (a_lt_b),
        .a_even  (a_even),
        .b_even  (b_even),
        .gcd_val (gcd_val)
    );

`ifndef GCD_BINARY_EN
    logic unused_bin;
    assign unused_bin = ^{mode, a_even, b_even};
`endif

    assign in_compute = (state_q == SUBT) || (state_q == SWAP) ||
                        (state_q == BSHIFT) || (state_q == BREDUCE);

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        err_d    = err_q;
        cycles_d = cycles_q;
        dp_op    = DP_HOLD;

        if (in_compute && (cycles_q != {CNT_W{1'b1}})) begin
            cycles_d = cycles_q + 1'b1;
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    dp_op    = DP_LOAD;
                    cycles_d = '0;
                    err_d    = 1'b0;
                    if ((a_in == '0) && (b_in == '0)) begin
                        result_d = '0;
                        err_d    = 1'b1;
                        state_d  = DONE;
                    end else if (a_in == '0) begin
                        result_d = b_in;
                        state_d  = DONE;
                    end else if (b_in == '0) begin
                        result_d = a_in;
                        state_d  = DONE;
                    end else begin
`ifdef GCD_BINARY_EN
                        state_d = (mode == GCD_MODE_BIN) ? BSHIFT : SUBT;
`else
                        state_d = SUBT;
`endif
                    end
                end
            end
            SUBT: begin
                if (a_eq_b) begin
                    result_d = gcd_val;
                    state_d  = DONE;
                end else if (a_lt_b) begin
                    state_d = SWAP;
                end else begin
                    dp_op = DP_SUB_AB;
                end
            end
            SWAP: begin
                dp_op   = DP_SWAP;
                state_d = SUBT;
            end
`ifdef GCD_BINARY_EN
            BSHIFT: begin
                if (a_even && b_even) begin
                    dp_op = DP_SHR_BOTH;
                end else begin
                    state_d = BREDUCE;
                end
            end
            BREDUCE: begin
                if (a_even) begin
                    dp_op = DP_SHR_A;
                end else if (b_even) begin
                    dp_op = DP_SHR_B;
                end else if (a_eq_b) begin
                    result_d = gcd_val;
                    state_d  = DONE;
                end else if (!a_lt_b) begin
                    dp_op = DP_SUB_AB;
                end else begin
                    dp_op = DP_SUB_BA;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            result_q <= '0;
            err_q    <= 1'b0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            err_q    <= err_d;
            cycles_q <= cycles_d;
        end
    end

    assign result = result_q;
    assign done   = (state_q == DONE);
    assign busy   = in_compute;
    assign err    = err_q;
    assign cycles = cycles_q;

endmodule

`default_nettype wire
